instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited request stream into imem, in-order response
// buffer feeding decode, and redirect flush that drops stale in-flight responses.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op,
    output logic [31:0] op_pc
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    logic          started;
    logic [31:0]   pc, rsp_pc;
    logic [CW-1:0] outstanding, outstanding_nxt, drop, count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW:0]   credit_used;
    logic          req_fire, push, pop;
    logic [31:0]   fifo_op [DEPTH];
    logic [31:0]   fifo_pc [DEPTH];

    // In-flight plus buffered never exceeds DEPTH, so every response has a slot.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = started & (credit_used < CREDITS) & ~redirect_valid;
    assign imem_req_addr  = {pc[31:2], 2'b00};
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign push           = imem_rsp_valid & ~redirect_valid & (drop == '0);
    assign op_valid       = (count != '0) & ~redirect_valid;
    assign pop            = op_valid & op_ready;
    assign op             = fifo_op[rd_ptr];
    assign op_pc          = fifo_pc[rd_ptr];

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !imem_rsp_valid)
            outstanding_nxt = outstanding + CNT_ONE;
        else if (!req_fire && imem_rsp_valid)
            outstanding_nxt = outstanding - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc     <= redirect_pc;
                rsp_pc <= redirect_pc;
                drop   <= outstanding_nxt;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (req_fire)
                    pc <= pc + 32'd4;
                if (imem_rsp_valid && drop != '0)
                    drop <= drop - CNT_ONE;
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop)
                    count <= count + CNT_ONE;
                else if (pop && !push)
                    count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_op[i] <= '0;
                fifo_pc[i] <= '0;
            end
        end else if (push) begin
            fifo_op[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr] <= rsp_pc;
        end
    end
endmodule
